// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into words, writes imem, releases the core.
// Optional checksum byte after the data phase: define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int WIDTH         = 32,
  parameter int IMEM_DEPTH    = 512,
  parameter int RELEASE_DELAY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
    CHK,
`endif
    RELEASE,
    RUN,
    ERROR
  } state_t;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = RELEASE;
`endif

  localparam logic [15:0] DEPTH    = 16'(IMEM_DEPTH);
  localparam logic [15:0] DLY_LAST = 16'(RELEASE_DELAY - 1);

  state_t      state, state_n;
  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] wbuf;
  logic [15:0] dly;
  logic [15:0] len_w;
  logic        accept;
  logic        last_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]  chk;
`endif

  assign len_w     = {in_data, len_lo};
  assign accept    = in_valid & in_ready;
  assign last_word = (byte_cnt == 2'd3) && (word_idx == count - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (state)
      IDLE: if (start) state_n = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_n = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (len_w == 16'd0)   state_n = TAIL;
          else if (len_w > DEPTH) state_n = ERROR;
          else                  state_n = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_word) state_n = TAIL;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid)
          state_n = ((chk ^ in_data) == 8'd0) ? RELEASE : ERROR;
      end
`endif
      RELEASE: begin
        busy = 1'b1;
        if (dly == DLY_LAST) state_n = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) state_n = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_n = LEN_LO;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: word assembly, write strobe and release timer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_lo   <= '0;
      count    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      wbuf     <= '0;
      dly      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      mem_en <= 1'b0;
      if (state == RELEASE) dly <= dly + 16'd1;
      else                  dly <= '0;
      if (accept) begin
        case (state)
          LEN_LO: begin
            len_lo <= in_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
            chk    <= in_data;
`endif
          end
          LEN_HI: begin
            count    <= len_w;
            word_idx <= '0;
            byte_cnt <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
          end
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            chk      <= chk ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_en   <= 1'b1;
              mem_addr <= WIDTH'(word_idx);
              mem_data <= WIDTH'({in_data, wbuf});
              word_idx <= word_idx + 16'd1;
            end else begin
              wbuf <= {in_data, wbuf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed boot scenarios plus random programs
// checked against a word-list reference model.
module tb_imem_boot_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int RDLY  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mem_en;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             cpu_reset;
  logic             busy;
  logic             done;
  logic             error;

  imem_boot_loader #(
    .WIDTH(WIDTH),
    .IMEM_DEPTH(DEPTH),
    .RELEASE_DELAY(RDLY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr = 0;
  int done_cyc = 0;
  bit done_q = 0;
  int bad_ready = 0;
  int bad_en = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] prog[$];

  always @(posedge clock) cyc++;

  // Observed write log and protocol watchers
  always @(negedge clock) begin
    if (mem_en) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      last_wr = cyc;
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
    if (in_ready && (done || error)) bad_ready++;
    if (mem_en && error) bad_en++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("accept_timeout", 64'(t), 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Streams length, prog[0..n-1] (little-endian) and, if enabled, the checksum byte
  task automatic load(input int n, input bit gaps, input bit badchk);
    logic [15:0] len;
    logic [7:0]  x;
    logic [31:0] w;
    len = 16'(n);
    x   = len[7:0] ^ len[15:8];
    send(len[7:0], gaps);
    send(len[15:8], gaps);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = prog[i];
        for (int k = 0; k < 4; k++) begin
          send(w[8*k +: 8], gaps);
          x = x ^ w[8*k +: 8];
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      send(badchk ? ~x : x, gaps);
`else
      if (badchk) x = 8'h00;
`endif
    end
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done && !error && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) check("wait_end_timeout", 64'(t), 64'd0);
    #1;
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_count"}, 64'(wa.size()), 64'(n));
    if (wa.size() == n)
      for (int i = 0; i < n; i++) begin
        check({tag, "_addr"}, 64'(wa[i]), 64'(i));
        check({tag, "_data"}, 64'(wd[i]), 64'(prog[i]));
      end
    wa.delete();
    wd.delete();
  endtask

  task automatic check_run(input string tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic two-word program
    prog = '{32'h0000_0013, 32'h0000_10B7};
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_cpu_reset_held", 64'(cpu_reset), 64'd1);
    load(2, 0, 0);
    wait_end();
    check_writes("t1", 2);
    check_run("t1");
`ifndef IMEM_BOOT_CHECKSUM_EN
    check("t1_release_delay", 64'(done_cyc - last_wr), 64'(RDLY));
`endif

    // Same stream with in_valid toggling
    pulse_start();
    check("t2_cpu_reset_rise", 64'(cpu_reset), 64'd1);
    load(2, 1, 0);
    wait_end();
    check_writes("t2", 2);
    check_run("t2");

    // Random programs, including the full-depth boundary
    for (int r = 0; r < 4; r++) begin
      n = (r == 3) ? DEPTH : int'($urandom_range(1, 8));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      pulse_start();
      load(n, (r == 1), 0);
      wait_end();
      check_writes("rnd", n);
      check_run("rnd");
    end

    // Oversized length
    pulse_start();
    load(DEPTH + 1, 0, 0);
    wait_end();
    check("t3_error", 64'(error), 64'd1);
    check("t3_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    repeat (5) @(negedge clock);
    check("t3_no_write", 64'(wa.size()), 64'd0);
    prog = '{32'hDEAD_BEEF};
    pulse_start();
    load(1, 0, 0);
    wait_end();
    check_writes("t3b", 1);
    check_run("t3b");

    // Reset mid-load after 6 data bytes; start held during reset
    prog = '{32'h4433_2211, 32'h0000_6655};
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < 6; i++) send(8'h11 * (i + 1), 0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    check("t4_mem_en", 64'(mem_en), 64'd0);
    check("t4_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t4_idle_busy", 64'(busy), 64'd0);
    check_writes("t4_partial", 1);
    prog = '{32'h0000_006F};
    pulse_start();
    load(1, 0, 0);
    wait_end();
    check_writes("t4b", 1);
    check_run("t4b");

    // Zero-length program
    pulse_start();
    load(0, 0, 0);
    wait_end();
    check_writes("t5", 0);
    check_run("t5");

`ifdef IMEM_BOOT_CHECKSUM_EN
    prog = '{32'h0000_0013, 32'h0000_10B7};
    pulse_start();
    load(2, 0, 1);
    wait_end();
    check("t6_error", 64'(error), 64'd1);
    check("t6_cpu_reset", 64'(cpu_reset), 64'd1);
    check_writes("t6", 2);
`endif

    check("ready_outside_load", 64'(bad_ready), 64'd0);
    check("mem_en_in_error", 64'(bad_en), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
